te_commit_scheduler: RTL and testbench
======================================

TE_COMMIT_SCHEDULER -- requirements
Module: te_commit_scheduler

Interface
REQ-001 Parameter NRET, default 2, number of commit lanes from the core.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, >= 2*NRET.
REQ-003 Parameter XLEN, default 64, instruction address width; itype width is mure_pkg::ITYPE_LEN.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 valid_i  in  NRET  per-lane commit valid; lane 0 is oldest.
REQ-007 itype_i  in  NRET x ITYPE_LEN  per-lane itype (mure_pkg::itype_e) from the per-lane itype detectors.
REQ-008 iaddr_i  in  NRET x XLEN  per-lane instruction address.
REQ-009 ready_o  out  1  buffer can accept all NRET lanes this cycle.
REQ-010 out_valid_o  out  1  head entry available to encoder.
REQ-011 out_itype_o  out  ITYPE_LEN  head entry itype.
REQ-012 out_iaddr_o  out  XLEN  head entry address.
REQ-013 out_ready_i  in  1  encoder accepts head entry.
REQ-014 count_o  out  clog2(DEPTH)+1  current occupancy.
REQ-015 drop_o  out  1  one-cycle pulse: valid lane(s) presented while ready_o low.
REQ-016 overflow_o  out  1  sticky: set by any drop, cleared only by reset.

Function
REQ-017 ready_o SHALL be combinational: 1 iff (DEPTH - count) >= NRET, evaluated on registered count only (no credit for same-cycle pop).
REQ-018 Push: when ready_o=1, every lane with valid_i=1 SHALL be written in ascending lane order into consecutive slots from the write pointer; invalid lanes are skipped (compaction, e.g. valid_i=2'b10 writes one entry).
REQ-019 npush = popcount(valid_i) when ready_o=1, else 0; write pointer advances by npush modulo DEPTH.
REQ-020 When ready_o=0 and valid_i != 0, no entry SHALL be written, drop_o SHALL pulse for that cycle and overflow_o SHALL set next edge.
REQ-021 Pop: when out_valid_o=1 and out_ready_i=1 the head entry SHALL be removed at the edge; read pointer advances by 1 modulo DEPTH.
REQ-022 out_valid_o = (count != 0); out_itype_o/out_iaddr_o driven combinationally from the head slot; when count=0 they SHALL read all zeros (itype STD).
REQ-023 Latency: entry pushed at edge N SHALL be visible at out_valid_o in cycle N+1; no input-to-output bypass.
REQ-024 Simultaneous push and pop SHALL be allowed; count_next = count + npush - pop, never exceeds DEPTH, never negative.
REQ-025 Ordering: entries SHALL leave in commit order (cycle order, then lane order); head SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-026 out_ready_i with count=0 SHALL have no effect.
REQ-027 Pointer wrap-around: slot index DEPTH-1 SHALL be followed by slot 0 for both pointers, including a 2-lane push straddling the wrap.
REQ-028 itype contents SHALL pass unmodified; the block applies no priority between itypes (EXC/INT ordering is that of the lanes).

Reset
REQ-029 During rst_i=1 (asserted at any time, incl. mid-push/pop): pointers, count_o=0, out_valid_o=0, out_itype_o=0, out_iaddr_o=0, drop_o=0, overflow_o=0; ready_o=1; buffered entries discarded.
REQ-030 First push SHALL be accepted on the first rising edge with rst_i=0.

Verification
REQ-031 Reset, then valid_i=2'b11, itype={TB,STD}, iaddr={0x104,0x100}, out_ready_i=1 -> next cycles output 0x100/STD then 0x104/TB, count 2->1->0.
REQ-032 out_ready_i=0, push 2 lanes twice (DEPTH=4) -> count_o=4, ready_o=0; third push valid_i=2'b01 -> drop_o=1 one cycle, overflow_o=1 stays set, count_o=4.
REQ-033 Count=3, valid_i=2'b11 with out_ready_i=1 -> ready_o=0 (no pop credit), drop_o=1, count_o=2 after edge.
REQ-034 valid_i=2'b10 iaddr[1]=0x200 EXC -> single entry 0x200/EXC, count_o=1.
REQ-035 Continuous 2-lane push with alternate pops for 20 cycles -> pointer wraps, output sequence equals input commit order, no entry lost or duplicated until drop.
REQ-036 rst_i asserted mid-stream with count_o=3 -> all outputs zero immediately, ready_o=1, overflow_o=0.

Source files
------------

// File: rtl/te_commit_scheduler.sv
// te_commit_scheduler: compacting multi-lane commit buffer feeding a single-entry-per-cycle trace encoder
package mure_pkg;
    localparam int ITYPE_LEN = 4;
    typedef enum logic [ITYPE_LEN-1:0] {
        STD  = 4'd0,
        EXC  = 4'd1,
        INT  = 4'd2,
        ERET = 4'd3,
        NTB  = 4'd4,
        TB   = 4'd5,
        UIJ  = 4'd6,
        IJ   = 4'd7
    } itype_e;
endpackage

module te_commit_scheduler #(
    parameter int NRET  = 2,
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NRET-1:0]                     valid_i,
    input  logic [NRET*mure_pkg::ITYPE_LEN-1:0] itype_i,
    input  logic [NRET*XLEN-1:0]                iaddr_i,
    output logic                                ready_o,
    output logic                                out_valid_o,
    output logic [mure_pkg::ITYPE_LEN-1:0]      out_itype_o,
    output logic [XLEN-1:0]                     out_iaddr_o,
    input  logic                                out_ready_i,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic                                drop_o,
    output logic                                overflow_o
);
    localparam int IL = mure_pkg::ITYPE_LEN;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IL-1:0]   itype_q [DEPTH];
    logic [XLEN-1:0] iaddr_q [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   slot [NRET];
    logic [CW-1:0]   nvalid, npush;
    logic            pop;

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        nvalid = '0;
        for (int l = 0; l < NRET; l++) begin
            slot[l] = wr_ptr + nvalid[PW-1:0];
            nvalid  = nvalid + CW'(valid_i[l]);
        end
    end

    assign ready_o     = count_o <= CW'(DEPTH - NRET);
    assign npush       = ready_o ? nvalid : '0;
    assign drop_o      = !ready_o && |valid_i;
    assign out_valid_o = count_o != '0;
    assign pop         = out_valid_o && out_ready_i;
    assign out_itype_o = out_valid_o ? itype_q[rd_ptr] : '0;
    assign out_iaddr_o = out_valid_o ? iaddr_q[rd_ptr] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + npush[PW-1:0];
            rd_ptr     <= rd_ptr + PW'(pop);
            count_o    <= count_o + npush - CW'(pop);
            overflow_o <= overflow_o | drop_o;
        end
    end

    // Slot contents need no reset: count gates visibility.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NRET; l++) begin
            if (ready_o && valid_i[l]) begin
                itype_q[slot[l]] <= itype_i[l*IL +: IL];
                iaddr_q[slot[l]] <= iaddr_i[l*XLEN +: XLEN];
            end
        end
    end
endmodule

// File: tb/tb_te_commit_scheduler.sv
// tb_te_commit_scheduler: directed steps against a queue scoreboard for te_commit_scheduler
module tb_te_commit_scheduler;
    import mure_pkg::*;

    typedef struct packed {
        logic [3:0]  it;
        logic [63:0] a;
    } ent_t;

    logic         clk = 0;
    logic         rst = 1;
    logic [1:0]   valid = '0;
    logic [7:0]   itype = '0;
    logic [127:0] iaddr = '0;
    logic         out_ready = 0;
    logic         ready, out_valid, drop, overflow;
    logic [3:0]   out_itype;
    logic [63:0]  out_iaddr;
    logic [2:0]   count;

    ent_t q[$];
    logic movf = 0;
    int   nvec = 0;
    int   nerr = 0;

    te_commit_scheduler #(.NRET(2), .DEPTH(4), .XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .itype_i(itype), .iaddr_i(iaddr),
        .ready_o(ready), .out_valid_o(out_valid), .out_itype_o(out_itype),
        .out_iaddr_o(out_iaddr), .out_ready_i(out_ready), .count_o(count),
        .drop_o(drop), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, compare against the model, then advance model and clock.
    task automatic step(input logic [1:0] v, input logic [3:0] it1, input logic [3:0] it0,
                        input logic [63:0] a1, input logic [63:0] a0, input logic ordy);
        logic mready, mdrop;
        valid = v;
        itype = {it1, it0};
        iaddr = {a1, a0};
        out_ready = ordy;
        #1;
        mready = (4 - q.size()) >= 2;
        mdrop  = !mready && (v != 0);
        chk("count", 64'(count), 64'(q.size()));
        chk("ready", 64'(ready), 64'(mready));
        chk("drop", 64'(drop), 64'(mdrop));
        chk("overflow", 64'(overflow), 64'(movf));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head_itype", 64'(out_itype), 64'(q[0].it));
            chk("head_iaddr", out_iaddr, q[0].a);
        end else begin
            chk("empty_itype", 64'(out_itype), 64'(STD));
            chk("empty_iaddr", out_iaddr, 64'h0);
        end
        if (ordy && q.size() != 0) void'(q.pop_front());
        if (mready && v[0]) q.push_back('{it0, a0});
        if (mready && v[1]) q.push_back('{it1, a1});
        movf = movf | mdrop;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_ready", 64'(ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);
        rst = 0;
        step(2'b11, TB, STD, 64'h104, 64'h100, 1);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b00, STD, STD, 0, 0, 1);
        // Fill to DEPTH, then a push must be dropped.
        step(2'b11, NTB, EXC, 64'h10c, 64'h108, 0);
        step(2'b11, INT, ERET, 64'h114, 64'h110, 0);
        step(2'b01, STD, IJ, 0, 64'h118, 0);
        step(2'b00, STD, STD, 0, 0, 0);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b11, UIJ, TB, 64'h124, 64'h120, 1);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b10, EXC, STD, 64'h200, 64'h1f0, 0);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b00, STD, STD, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(2'b11, 4'(i % 8), 4'((i + 3) % 8), 64'h1000 + 64'(8 * i + 4),
                 64'h1000 + 64'(8 * i), i[0]);
        for (int i = 0; i < 8; i++) step(2'b00, STD, STD, 0, 0, 1);
        chk("drained", 64'(count), 64'h0);
        step(2'b11, TB, NTB, 64'h304, 64'h300, 0);
        step(2'b01, STD, EXC, 0, 64'h308, 0);
        chk("pre_rst_count", 64'(count), 64'h3);
        valid = 2'b11;
        out_ready = 1;
        rst = 1;
        #1;
        chk("mid_rst_count", 64'(count), 64'h0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_itype", 64'(out_itype), 64'h0);
        chk("mid_rst_iaddr", out_iaddr, 64'h0);
        chk("mid_rst_ready", 64'(ready), 64'h1);
        chk("mid_rst_overflow", 64'(overflow), 64'h0);
        chk("mid_rst_drop", 64'(drop), 64'h0);
        q.delete();
        movf = 0;
        @(posedge clk);
        #1;
        rst = 0;
        step(2'b01, STD, INT, 0, 64'h400, 0);
        step(2'b00, STD, STD, 0, 0, 1);
        step(2'b00, STD, STD, 0, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
